// File: rtl/reshaper_pkg.sv
// Shared types and defaults for the reshaper write-back buffer.
//   WBUF_AW / WBUF_DW : address / data widths of a buffered write
//   WBUF_DEPTH        : default FIFO depth
//   wbuf_entry_t      : one buffered write {addr, data}
package reshaper_pkg;

  localparam int unsigned WBUF_AW    = 16;
  localparam int unsigned WBUF_DW    = 512;
  localparam int unsigned WBUF_DEPTH = 8;

  typedef struct packed {
    logic [WBUF_AW-1:0] addr;
    logic [WBUF_DW-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/reshaper_wbuf_fifo.sv
// Synchronous FIFO of wbuf_entry_t with an in-place tail-data overwrite port.
//   clk          : clock, rising edge
//   clr_i        : synchronous clear of pointers and count (contents kept)
//   push_i       : write push_entry_i at the tail
//   pop_i        : advance the head (caller guarantees not empty)
//   ovr_i        : overwrite data of the current tail entry with ovr_data_i
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_o      : occupancy, $clog2(DEPTH)+1 bits
//   head_o       : head entry, read straight from the storage registers
//   tail_addr_o  : address of the newest entry (RESHAPER_WBUF_MERGE_EN only)
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module reshaper_wbuf_fifo
  import reshaper_pkg::*;
#(
  parameter  int unsigned DEPTH = WBUF_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic               push_i,
  input  wbuf_entry_t        push_entry_i,
  input  logic               pop_i,
  input  logic               ovr_i,
  input  logic [WBUF_DW-1:0] ovr_data_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [CW-1:0]      count_o,
  output wbuf_entry_t        head_o
`ifdef RESHAPER_WBUF_MERGE_EN
  ,
  output logic [WBUF_AW-1:0] tail_addr_o
`endif
);

  wbuf_entry_t       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     tail_ptr;

  assign tail_ptr = wr_ptr_q - PW'(1);

  // Pointer and occupancy next-state; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage is not cleared; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    if (ovr_i)  mem_q[tail_ptr].data <= ovr_data_i;
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

`ifdef RESHAPER_WBUF_MERGE_EN
  assign tail_addr_o = mem_q[tail_ptr].addr;
`endif

endmodule

// File: rtl/reshaper_wbuf.sv
// Write-back buffer behind the reshaper: absorbs the unthrottled write stream
// into a FIFO and drains it to memory under valid/ready.
//   clk, reset           : clock and synchronous active-high reset
//   init_pulse           : job start, clears everything like reset
//   waddr/wdata/wdata_vld: reshaper write stream (no backpressure)
//   finish               : reshaper end-of-job pulse
//   mem_waddr/mem_wdata  : head entry (0 while empty)
//   mem_wvld / mem_wrdy  : memory handshake, pop on both high
//   done                 : finish seen and all writes accepted; held
//   overflow             : sticky, a write was dropped on a full FIFO
//   wr_count             : memory writes accepted this job, wraps
// Optional feature: define RESHAPER_WBUF_MERGE_EN to merge a write whose
// address matches the tail entry into that entry instead of allocating.
// AW and DW must equal the reshaper_pkg entry widths.
module reshaper_wbuf
  import reshaper_pkg::*;
#(
  parameter int unsigned AW    = WBUF_AW,
  parameter int unsigned DW    = WBUF_DW,
  parameter int unsigned DEPTH = WBUF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init_pulse,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          wdata_vld,
  input  logic          finish,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wvld,
  input  logic          mem_wrdy,
  output logic          done,
  output logic          overflow,
  output logic [AW-1:0] wr_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clr_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic          merge_c;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  wbuf_entry_t   push_entry;
  wbuf_entry_t   head;

  // finish_seen/done walk IDLE -> FLUSH -> DONE.
  logic          finish_seen_q, finish_seen_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_count_q, wr_count_d;

  assign clr_c = reset | init_pulse;
  assign pop_c = mem_wvld & mem_wrdy;

`ifdef RESHAPER_WBUF_MERGE_EN
  logic [WBUF_AW-1:0] tail_addr;
  // Merge only into a tail that stays resident this cycle.
  assign merge_c = wdata_vld & ~fifo_empty & (tail_addr == waddr)
                 & ~(pop_c & (fifo_count == CW'(1)));
`else
  assign merge_c = 1'b0;
`endif

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_c = wdata_vld & ~merge_c & (~fifo_full | pop_c);
  assign drop_c = wdata_vld & ~merge_c & fifo_full & ~pop_c;

  assign push_entry.addr = waddr;
  assign push_entry.data = wdata;

  reshaper_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .clr_i        (clr_c),
    .push_i       (push_c),
    .push_entry_i (push_entry),
    .pop_i        (pop_c),
    .ovr_i        (merge_c),
    .ovr_data_i   (wdata),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .head_o       (head)
`ifdef RESHAPER_WBUF_MERGE_EN
    ,
    .tail_addr_o  (tail_addr)
`endif
  );

  // Job flags and counters.
  always_comb begin
    finish_seen_d = finish_seen_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    wr_count_d    = wr_count_q;
    if (clr_c) begin
      finish_seen_d = 1'b0;
      done_d        = 1'b0;
      overflow_d    = 1'b0;
      wr_count_d    = '0;
    end else begin
      if (finish) finish_seen_d = 1'b1;
      if (finish_seen_q && (fifo_count == '0) && !wdata_vld) done_d = 1'b1;
      if (drop_c) overflow_d = 1'b1;
      if (pop_c)  wr_count_d = wr_count_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    finish_seen_q <= finish_seen_d;
    done_q        <= done_d;
    overflow_q    <= overflow_d;
    wr_count_q    <= wr_count_d;
  end

  assign mem_wvld  = ~fifo_empty;
  assign mem_waddr = fifo_empty ? '0 : head.addr;
  assign mem_wdata = fifo_empty ? '0 : head.data;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign wr_count  = wr_count_q;

endmodule
